// File: rtl/sh_sequencer.sv
`timescale 1ns/1ps
// sh_sequencer
// -----------------------------------------------------------------------------
// Initiator-side controller for the sample_hold interface. A conversion has
// three steps:
//   1. Drive sample_en high for T = max(track_cycles,1) cycles (track).
//   2. Hold it low while the held outputs settle.
//   3. Capture sh_vout_p - sh_vout_n as a signed (DATA_W+1)-bit value.
// The captured value is presented on a valid/ready stream toward the
// quantizer. In continuous mode the next track window opens on the
// handshake edge itself, with no idle cycle in between.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   enable           block enable; low forces IDLE and drops any pending result
//   start            single-shot conversion request
//   cont_mode        back-to-back conversions while set
//   track_cycles     track window length (0 behaves as 1)
//   settle_cycles    settle window length (values below 2 behave as 2)
//   sample_en        to the S/H; high = track
//   sh_vout_p/_n     held differential outputs from the S/H
//   result_data      signed sh_vout_p - sh_vout_n, stable while valid
//   result_valid     result available
//   result_ready     downstream accepts the result
//   busy             high in any state other than IDLE
//   overrun_cnt      saturating count of start requests seen while busy
// -----------------------------------------------------------------------------
module sh_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [CNT_W-1:0]  track_cycles,
  input  logic [3:0]        settle_cycles,
  output logic              sample_en,
  input  logic [DATA_W-1:0] sh_vout_p,
  input  logic [DATA_W-1:0] sh_vout_n,
  output logic [DATA_W:0]   result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  overrun_cnt
);

  typedef enum logic [1:0] {IDLE, TRACK, SETTLE, OUT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_settle;
  logic              r_sampleEn;
  logic [DATA_W:0]   r_resultData;
  logic              r_resultValid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_overrun;

  logic [CNT_W-1:0]  w_trackLoad;
  logic [3:0]        w_settleLoad;
  logic [DATA_W:0]   w_diff;
  logic              w_handshake;

  // The down-counter runs from T-1 to 0 during track, so the load value is
  // the clamped length minus one (a zero request collapses to a single cycle).
  assign w_trackLoad  = (track_cycles == '0) ? '0 : track_cycles - CNT_W'(1);
  assign w_settleLoad = (settle_cycles < 4'd2) ? 4'd2 : settle_cycles;
  // Zero-extension of both operands makes the wrap-around difference the
  // exact two's-complement result; the full range fits in DATA_W+1 bits.
  assign w_diff       = {1'b0, sh_vout_p} - {1'b0, sh_vout_n};
  assign w_handshake  = r_resultValid && result_ready;

  // Conversion FSM.
  // Window lengths are latched on every transition into TRACK, so any
  // mid-conversion change to track_cycles/settle_cycles waits for the next one.
  // The settle counter is loaded with S and captures when it reaches zero,
  // which places the capture edge S+1 edges after track ends.
  // Overrun counting is independent of enable so that it only ever reflects
  // requests that arrived while a conversion was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_settle      <= 4'd2;
      r_sampleEn    <= 1'b0;
      r_resultData  <= '0;
      r_resultValid <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= '0;
    end else begin
      if (start && (r_state != IDLE) && (r_overrun != '1))
        r_overrun <= r_overrun + CNT_W'(1);

      if (!enable) begin
        r_state       <= IDLE;
        r_sampleEn    <= 1'b0;
        r_resultValid <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start || cont_mode) begin
              r_state    <= TRACK;
              r_sampleEn <= 1'b1;
              r_busy     <= 1'b1;
              r_cnt      <= w_trackLoad;
              r_settle   <= w_settleLoad;
            end
          end
          TRACK: begin
            if (r_cnt == '0) begin
              r_state    <= SETTLE;
              r_sampleEn <= 1'b0;
              r_cnt      <= CNT_W'(r_settle);
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          SETTLE: begin
            if (r_cnt == '0) begin
              r_state       <= OUT;
              r_resultData  <= w_diff;
              r_resultValid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          OUT: begin
            if (w_handshake) begin
              r_resultValid <= 1'b0;
              if (cont_mode) begin
                r_state    <= TRACK;
                r_sampleEn <= 1'b1;
                r_cnt      <= w_trackLoad;
                r_settle   <= w_settleLoad;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state    <= IDLE;
            r_sampleEn <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_en    = r_sampleEn;
  assign result_data  = r_resultData;
  assign result_valid = r_resultValid;
  assign busy         = r_busy;
  assign overrun_cnt  = r_overrun;

endmodule
